// File: rtl/ifu_fetch.sv
// Instruction fetch: owns the PC, drives the ROM read port, realigns sync ROM data with its address.
// Latency: address issued in cycle n is presented on inst_o in cycle n+1; one word per cycle.
// Backpressure: hold_i freezes PC and the presented word; jump_en_i overrides hold and squashes one word.
//
// Ports:
//   clk, rst                     clock and asynchronous active-high reset
//   hold_i                       stall: keep PC and presented instruction stable
//   jump_en_i, jump_addr_i       single-cycle redirect and its byte target (low 2 bits dropped)
//   rom_r_en_o, rom_r_addr_o     ROM read port (word-aligned byte address)
//   rom_r_data_i                 ROM data, valid the cycle after a read enable
//   inst_o, inst_addr_o,
//   inst_valid_o                 instruction, its byte address and validity towards IF/ID
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold_i,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  output logic        rom_r_en_o,
  output logic [31:0] rom_r_addr_o,
  input  logic [31:0] rom_r_data_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [31:0] pc;
  logic [31:0] f1_addr;    // address of the word the ROM returns this cycle
  logic        f1_valid;
  logic [31:0] hold_buf;   // presented word frozen while stalled (ROM data is stale then)
  logic        buf_valid;

  logic        issue;
  logic        capture;
  logic [31:0] issue_addr;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: a jump always lands in S_RUN, otherwise hold decides
  always_comb begin
    state_nxt = state;
    case (state)
      S_BOOT, S_RUN: state_nxt = (hold_i && !jump_en_i) ? S_HOLD : S_RUN;
      S_HOLD:        state_nxt = (jump_en_i || !hold_i) ? S_RUN : S_HOLD;
      default:       state_nxt = S_RUN;
    endcase
  end

  // Outputs and control strobes
  always_comb begin
    issue        = jump_en_i || !hold_i;
    // Capture only on the edge that enters the stall; later hold cycles keep the buffer.
    capture      = (state != S_HOLD) && hold_i && !jump_en_i;
    issue_addr   = jump_en_i ? {jump_addr_i[31:2], 2'b00} : pc;
    rom_r_en_o   = !rst && issue;
    rom_r_addr_o = issue_addr;
    inst_addr_o  = f1_addr;
    // A jump in flight squashes whatever word is on the output this cycle.
    inst_valid_o = f1_valid && !jump_en_i;
    if (!inst_valid_o) begin
      inst_o = NOP_INST;
    end else if (buf_valid) begin
      inst_o = hold_buf;
    end else begin
      inst_o = rom_r_data_i;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_PC;
      f1_addr   <= 32'h0000_0000;
      f1_valid  <= 1'b0;
      hold_buf  <= NOP_INST;
      buf_valid <= 1'b0;
    end else if (issue) begin
      pc        <= issue_addr + 32'd4;
      f1_addr   <= issue_addr;
      f1_valid  <= 1'b1;
      buf_valid <= 1'b0;
    end else if (capture) begin
      hold_buf  <= inst_o;
      buf_valid <= f1_valid;
    end
  end

endmodule
